// File: rtl/instr_fetch_decode.sv
// rtl/instr_fetch_decode.sv - PC owner, instruction fetch and field decode for the 16-bit CPU
module instr_fetch_decode #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic              issue_valid,
  input  logic              issue_ready,
  output logic [4:0]        opp,
  output logic [2:0]        R1,
  output logic [2:0]        R2,
  output logic [2:0]        QR,
  output logic [1:0]        RES,
  output logic [7:0]        imm8,
  input  logic [15:0]       jmp_target,
  input  logic              flag_gt,
  input  logic              flag_lt,
  input  logic              flag_eq,
  output logic              halted,
  output logic              illegal
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_ISSUE  = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_MOV  = 5'd11;
  localparam logic [4:0] OP_JMP  = 5'd12;
  localparam logic [4:0] OP_JGO  = 5'd13;
  localparam logic [4:0] OP_JLO  = 5'd14;
  localparam logic [4:0] OP_JEO  = 5'd15;
  localparam logic [4:0] OP_HLT  = 5'd16;
  localparam logic [4:0] OP_RST  = 5'd17;
  localparam logic [4:0] OP_SETH = 5'd18;
  localparam logic [4:0] OP_SETL = 5'd19;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [15:0]       r_ir;

  logic [4:0]        w_opp;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_jmp_pc;
  logic              w_reserved;
  logic              w_unused_jmp_hi;

  assign w_opp      = r_ir[15:11];
  assign w_pc_inc   = r_pc + ADDR_W'(1);
  assign w_jmp_pc   = jmp_target[ADDR_W-1:0];
  assign w_reserved = (w_opp > OP_SETL);

  // Only the low ADDR_W bits of the register value can address program memory
  assign w_unused_jmp_hi = ^jmp_target[15:ADDR_W];

  // Sequencer: fetch one word, decode it for a single cycle, then either issue it or resolve it locally
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_ir    <= 16'h0000;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem_ack) begin
            r_ir    <= imem_rdata;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (((w_opp > OP_NOP) && (w_opp <= OP_MOV)) || (w_opp == OP_SETH) || (w_opp == OP_SETL)) begin
            r_state <= S_ISSUE;
          end else if (w_opp == OP_HLT) begin
            r_state <= S_HALT;
          end else begin
            r_state <= S_FETCH;
            case (w_opp)
              OP_JMP:  r_pc <= w_jmp_pc;
              OP_JGO:  r_pc <= flag_gt ? w_jmp_pc : w_pc_inc;
              OP_JLO:  r_pc <= flag_lt ? w_jmp_pc : w_pc_inc;
              OP_JEO:  r_pc <= flag_eq ? w_jmp_pc : w_pc_inc;
              OP_RST:  r_pc <= RESET_PC;
              default: r_pc <= w_pc_inc;
            endcase
          end
        end
        S_ISSUE: begin
          if (issue_ready) begin
            r_pc    <= w_pc_inc;
            r_state <= S_FETCH;
          end
        end
        default: begin
          r_state <= S_HALT;
        end
      endcase
    end
  end

  assign imem_req    = (r_state == S_FETCH);
  assign imem_addr   = r_pc;
  assign issue_valid = (r_state == S_ISSUE);
  assign halted      = (r_state == S_HALT);
  assign illegal     = (r_state == S_DECODE) && w_reserved;

  assign opp  = r_ir[15:11];
  assign R1   = r_ir[10:8];
  assign R2   = r_ir[7:5];
  assign QR   = r_ir[4:2];
  assign RES  = r_ir[1:0];
  assign imm8 = r_ir[7:0];

endmodule

// File: tb/tb_instr_fetch_decode.sv
// tb/tb_instr_fetch_decode.sv - directed table and sequence bench for instr_fetch_decode
module tb_instr_fetch_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        issue_valid;
  logic        issue_ready;
  logic [4:0]  opp;
  logic [2:0]  R1;
  logic [2:0]  R2;
  logic [2:0]  QR;
  logic [1:0]  RES;
  logic [7:0]  imm8;
  logic [15:0] jmp_target;
  logic        flag_gt;
  logic        flag_lt;
  logic        flag_eq;
  logic        halted;
  logic        illegal;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] tgt;
    logic [2:0]  flags;   // {gt, lt, eq}
    logic        exp_issue;
    logic        exp_illegal;
    logic [23:0] exp_fields; // {opp, R1, R2, QR, RES, imm8}
    logic [7:0]  addr;
    logic [7:0]  next;
  } vec_t;

  vec_t vecs[14];

  instr_fetch_decode #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .opp         (opp),
    .R1          (R1),
    .R2          (R2),
    .QR          (QR),
    .RES         (RES),
    .imm8        (imm8),
    .jmp_target  (jmp_target),
    .flag_gt     (flag_gt),
    .flag_lt     (flag_lt),
    .flag_eq     (flag_eq),
    .halted      (halted),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] mkf(input int o, input int a, input int b, input int q, input int r, input int im);
    return {5'(o), 3'(a), 3'(b), 3'(q), 2'(r), 8'(im)};
  endfunction

  function automatic vec_t mkv(input logic [15:0] instr, input logic [15:0] tgt, input logic [2:0] flags,
                               input logic iss, input logic ill, input logic [23:0] f,
                               input logic [7:0] addr, input logic [7:0] next);
    vec_t v;
    v.instr = instr; v.tgt = tgt; v.flags = flags; v.exp_issue = iss; v.exp_illegal = ill;
    v.exp_fields = f; v.addr = addr; v.next = next;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [23:0] fields_now();
    return {opp, R1, R2, QR, RES, imm8};
  endfunction

  // Waits (bounded) for a fetch request and checks it targets the expected address
  task automatic wait_req(input string nm, input logic [7:0] exp_addr);
    int k = 0;
    while (!imem_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({nm, "_req"}, 32'(imem_req), 32'd1);
    check({nm, "_addr"}, 32'(imem_addr), 32'(exp_addr));
  endtask

  // Acks the pending fetch with a word; returns at the negedge of the DECODE cycle
  task automatic give_word(input logic [15:0] w, input logic [15:0] tgt, input logic [2:0] fl);
    imem_ack = 1'b1;
    imem_rdata = w;
    jmp_target = tgt;
    {flag_gt, flag_lt, flag_eq} = fl;
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = 16'h0000;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string nm;
    nm = $sformatf("v%0d", idx);
    wait_req(nm, v.addr);
    give_word(v.instr, v.tgt, v.flags);
    check({nm, "_dec_illegal"}, 32'(illegal), 32'(v.exp_illegal));
    check({nm, "_dec_valid"}, 32'(issue_valid), 32'd0);
    check({nm, "_dec_req"}, 32'(imem_req), 32'd0);
    @(negedge clk);
    {flag_gt, flag_lt, flag_eq} = 3'b000;
    check({nm, "_valid"}, 32'(issue_valid), 32'(v.exp_issue));
    if (v.exp_issue) begin
      check({nm, "_fields"}, 32'(fields_now()), 32'(v.exp_fields));
      issue_ready = 1'b1;
      @(negedge clk);
      issue_ready = 1'b0;
    end else begin
      check({nm, "_illegal_gone"}, 32'(illegal), 32'd0);
    end
    check({nm, "_next_req"}, 32'(imem_req), 32'd1);
    check({nm, "_next_addr"}, 32'(imem_addr), 32'(v.next));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mkv(16'h0D28, 16'h0000, 3'b000, 1'b1, 1'b0, mkf(1, 5, 1, 2, 0, 8'h28),   8'h00, 8'h01);
    vecs[1]  = mkv(16'h98AB, 16'h0000, 3'b000, 1'b1, 1'b0, mkf(19, 0, 5, 2, 3, 8'hAB),  8'h01, 8'h02);
    vecs[2]  = mkv(16'h6800, 16'h01F3, 3'b100, 1'b0, 1'b0, 24'h0,                        8'h02, 8'hF3);
    vecs[3]  = mkv(16'h6800, 16'h01F3, 3'b011, 1'b0, 1'b0, 24'h0,                        8'hF3, 8'hF4);
    vecs[4]  = mkv(16'h7000, 16'h0010, 3'b010, 1'b0, 1'b0, 24'h0,                        8'hF4, 8'h10);
    vecs[5]  = mkv(16'h7800, 16'h0020, 3'b110, 1'b0, 1'b0, 24'h0,                        8'h10, 8'h11);
    vecs[6]  = mkv(16'h7800, 16'h0040, 3'b001, 1'b0, 1'b0, 24'h0,                        8'h11, 8'h40);
    vecs[7]  = mkv(16'h6000, 16'hABFF, 3'b000, 1'b0, 1'b0, 24'h0,                        8'h40, 8'hFF);
    vecs[8]  = mkv(16'h0000, 16'h0000, 3'b000, 1'b0, 1'b0, 24'h0,                        8'hFF, 8'h00);
    vecs[9]  = mkv(16'hF800, 16'h0000, 3'b000, 1'b0, 1'b1, 24'h0,                        8'h00, 8'h01);
    vecs[10] = mkv(16'hA000, 16'h0000, 3'b000, 1'b0, 1'b1, 24'h0,                        8'h01, 8'h02);
    vecs[11] = mkv(16'h5FFF, 16'h0000, 3'b000, 1'b1, 1'b0, mkf(11, 7, 7, 7, 3, 8'hFF),  8'h02, 8'h03);
    vecs[12] = mkv(16'h8800, 16'h0000, 3'b000, 1'b0, 1'b0, 24'h0,                        8'h03, 8'h00);
    vecs[13] = mkv(16'h1A4D, 16'h0000, 3'b000, 1'b1, 1'b0, mkf(3, 2, 2, 3, 1, 8'h4D),   8'h00, 8'h01);

    rst_n = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = 16'h0000;
    issue_ready = 1'b0;
    jmp_target = 16'h0000;
    {flag_gt, flag_lt, flag_eq} = 3'b000;
    @(negedge clk);
    @(negedge clk);
    check("rst_valid",   32'(issue_valid), 32'd0);
    check("rst_halted",  32'(halted),      32'd0);
    check("rst_illegal", 32'(illegal),     32'd0);
    check("rst_fields",  32'(fields_now()), 32'd0);
    check("rst_addr",    32'(imem_addr),   32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      run_vec(vecs[i], i);
    end

    // HLT at PC 1: no more fetches until reset, then restart at RESET_PC
    wait_req("hlt", 8'h01);
    give_word(16'h8000, 16'h0000, 3'b000);
    check("hlt_dec_halted", 32'(halted), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("hlt_halted_%0d", i), 32'(halted),   32'd1);
      check($sformatf("hlt_req_%0d", i),    32'(imem_req), 32'd0);
      check($sformatf("hlt_addr_%0d", i),   32'(imem_addr), 32'h01);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("hlt_rst_halted", 32'(halted), 32'd0);
    @(negedge clk);
    check("hlt_rst_req",  32'(imem_req),  32'd1);
    check("hlt_rst_addr", 32'(imem_addr), 32'h00);

    // Slow memory: ack withheld 4 cycles, then Control stalls 3 cycles
    for (int i = 0; i < 4; i++) begin
      check($sformatf("stall_req_%0d", i),  32'(imem_req),  32'd1);
      check($sformatf("stall_addr_%0d", i), 32'(imem_addr), 32'h00);
      @(negedge clk);
    end
    check("stall_req_4", 32'(imem_req), 32'd1);
    give_word(16'h0D28, 16'h0000, 3'b000);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("hold_valid_%0d", i),  32'(issue_valid), 32'd1);
      check($sformatf("hold_fields_%0d", i), 32'(fields_now()), 32'(mkf(1, 5, 1, 2, 0, 8'h28)));
      check($sformatf("hold_addr_%0d", i),   32'(imem_addr), 32'h00);
      check($sformatf("hold_req_%0d", i),    32'(imem_req), 32'd0);
      @(negedge clk);
    end
    issue_ready = 1'b1;
    @(negedge clk);
    issue_ready = 1'b0;
    check("hold_next_valid", 32'(issue_valid), 32'd0);
    check("hold_next_addr",  32'(imem_addr),   32'h01);

    // Reset while an issue is pending and unaccepted
    wait_req("mid", 8'h01);
    give_word(16'h1A4D, 16'h0000, 3'b000);
    @(negedge clk);
    check("mid_valid_before", 32'(issue_valid), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_valid_after", 32'(issue_valid), 32'd0);
    check("mid_addr_after",  32'(imem_addr),   32'h00);
    check("mid_fields_after", 32'(fields_now()), 32'd0);
    @(negedge clk);
    check("mid_refetch_req",  32'(imem_req),  32'd1);
    check("mid_refetch_addr", 32'(imem_addr), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
